// File: rtl/seq_pattern_generator.sv
// Purpose  : serial bit-pattern transmitter feeding a sequence-detector input, one bit per clock,
//            with programmable repeat count and idle gap cycles between repetitions.
// Latency  : start sampled at edge N -> LOAD after edge N -> first bit after edge N+1; all outputs registered.
// Backpres.: none; start is ignored while busy (no queueing), abort returns to IDLE immediately.
//
// Ports:
//   clock, resetn          rising-edge clock, synchronous active-low reset
//   start_i, abort_i       start request (IDLE only), abort (priority over start)
//   pattern_i              bits to send, bit length-1 first (MSB-first)
//   length_i               bits per repetition (clamped to MAX_LEN, 0 = ignore start)
//   repeat_i, gap_i        extra repetitions, idle cycles between repetitions
//   w_out_o, w_valid_o     serial bit and its qualifier (w_out_o is 0 when not valid)
//   busy_o, done_o         transfer in progress, one-cycle completion pulse
//   state_o                current FSM state code for LED display
module seq_pattern_generator #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [MAX_LEN-1:0] pattern_i,
    input  logic [LEN_W-1:0]   length_i,
    input  logic [LEN_W-1:0]   repeat_i,
    input  logic [LEN_W-1:0]   gap_i,
    output logic               w_out_o,
    output logic               w_valid_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [2:0]         state_o
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SEND = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   gap_q, gap_d;
    logic [LEN_W-1:0]   rep_q, rep_d;
    logic [LEN_W-1:0]   gcnt_q, gcnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               w_out_q, w_out_d;
    logic               w_valid_q, w_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [LEN_W-1:0]   len_clamp;
    logic [IDX_W-1:0]   len_m1;
    logic [IDX_W-1:0]   idx_dec;

    assign len_clamp = (length_i > MAX_LEN_L) ? MAX_LEN_L : length_i;
    // len_q is never 0 once latched, so len_q-1 always fits the index width.
    assign len_m1    = IDX_W'(len_q - LEN_W'(1));
    assign idx_dec   = idx_q - IDX_W'(1);

    // idx_q holds the index of the bit currently on the line while in SEND;
    // each branch that lands in SEND also computes the bit to present next cycle.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        gap_d     = gap_q;
        rep_d     = rep_q;
        gcnt_d    = gcnt_q;
        idx_d     = idx_q;
        w_out_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Config is captured on the accepting edge so it is stable
                // throughout LOAD and unaffected by later input changes.
                if (start_i && !abort_i && (length_i != '0)) begin
                    state_d = S_LOAD;
                    pat_d   = pattern_i;
                    len_d   = len_clamp;
                    gap_d   = gap_i;
                    rep_d   = repeat_i;
                    gcnt_d  = '0;
                end
            end
            S_LOAD: begin
                state_d = S_SEND;
                idx_d   = len_m1;
                w_out_d = pat_q[len_m1];
            end
            S_SEND: begin
                if (idx_q != '0) begin
                    idx_d   = idx_dec;
                    w_out_d = pat_q[idx_dec];
                end else if (rep_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    rep_d = rep_q - LEN_W'(1);
                    if (gap_q != '0) begin
                        state_d = S_GAP;
                        gcnt_d  = gap_q;
                    end else begin
                        // Back-to-back repetition: no bubble between last and first bit.
                        idx_d   = len_m1;
                        w_out_d = pat_q[len_m1];
                    end
                end
            end
            S_GAP: begin
                if (gcnt_q <= LEN_W'(1)) begin
                    state_d = S_SEND;
                    gcnt_d  = '0;
                    idx_d   = len_m1;
                    w_out_d = pat_q[len_m1];
                end else begin
                    gcnt_d = gcnt_q - LEN_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            w_out_d = 1'b0;
        end

        w_valid_d = (state_d == S_SEND);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            gap_q     <= '0;
            rep_q     <= '0;
            gcnt_q    <= '0;
            idx_q     <= '0;
            w_out_q   <= 1'b0;
            w_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            gap_q     <= gap_d;
            rep_q     <= rep_d;
            gcnt_q    <= gcnt_d;
            idx_q     <= idx_d;
            w_out_q   <= w_out_d;
            w_valid_q <= w_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign w_out_o   = w_out_q;
    assign w_valid_o = w_valid_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_seq_pattern_generator.sv
// Purpose  : self-checking bench for seq_pattern_generator; stimulus pushes expected bits/done
//            pulses (with the cycle they must appear) into a queue, a negedge monitor pops and compares.
// Latency  : cycle counter increments on every rising edge; outputs are sampled on the falling edge.
module tb_seq_pattern_generator;

    logic       clock = 1'b0;
    logic       resetn;
    logic       start_i;
    logic       abort_i;
    logic [7:0] pattern_i;
    logic [3:0] length_i;
    logic [3:0] repeat_i;
    logic [3:0] gap_i;
    logic       w_out_o;
    logic       w_valid_o;
    logic       busy_o;
    logic       done_o;
    logic [2:0] state_o;

    seq_pattern_generator #(.MAX_LEN(8), .LEN_W(4)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .start_i   (start_i),
        .abort_i   (abort_i),
        .pattern_i (pattern_i),
        .length_i  (length_i),
        .repeat_i  (repeat_i),
        .gap_i     (gap_i),
        .w_out_o   (w_out_o),
        .w_valid_o (w_valid_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .state_o   (state_o)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int   cyc;
        bit   is_done;
        logic val;
    } item_t;

    item_t sb[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input bit d, input logic v);
        item_t it;
        it.cyc     = c;
        it.is_done = d;
        it.val     = v;
        sb.push_back(it);
    endtask

    // Monitor: every presented bit or done pulse must match the head of the scoreboard.
    always @(negedge clock) begin
        item_t it;
        if (w_valid_o || done_o) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output w_valid=%0b done=%0b w_out=%0b required=none (cycle %0d)",
                         w_valid_o, done_o, w_out_o, cyc);
            end else begin
                it = sb.pop_front();
                chk("out_cycle", cyc, it.cyc);
                chk("out_is_done", {31'b0, done_o}, {31'b0, it.is_done});
                if (!it.is_done) chk("w_out", {31'b0, w_out_o}, {31'b0, it.val});
            end
        end else if (w_out_o !== 1'b0) begin
            chk("w_out_idle_zero", {31'b0, w_out_o}, 32'd0);
        end
    end

    // Called at a falling edge; start is sampled at the next rising edge (edge n).
    task automatic launch(input logic [7:0] pat, input logic [3:0] len, input logic [3:0] rep,
                          input logic [3:0] gp, output int n);
        pattern_i = pat;
        length_i  = len;
        repeat_i  = rep;
        gap_i     = gp;
        start_i   = 1'b1;
        n         = cyc + 1;
        @(negedge clock);
        start_i   = 1'b0;
    endtask

    // exp holds the hand-computed bits of one repetition, first-sent bit at exp[nb-1].
    task automatic expect_stream(input int n, input logic [7:0] exp, input int nb,
                                 input int rep, input int gp);
        int s = 0;
        for (int r = 0; r <= rep; r++) begin
            for (int i = 0; i < nb; i++) begin
                push(n + 1 + s, 1'b0, exp[nb-1-i]);
                s++;
            end
            if (r < rep) s += gp;
        end
        push(n + 1 + s, 1'b1, 1'b0);
        repeat (s + 3) @(negedge clock);
        chk("busy_after_done", {31'b0, busy_o}, 32'd0);
        chk("state_after_done", {29'b0, state_o}, 32'd0);
    endtask

    initial begin
        int n;
        resetn    = 1'b0;
        start_i   = 1'b0;
        abort_i   = 1'b0;
        pattern_i = '0;
        length_i  = '0;
        repeat_i  = '0;
        gap_i     = '0;
        repeat (3) @(negedge clock);
        chk("rst_state", {29'b0, state_o}, 32'd0);
        chk("rst_outs", {28'b0, w_out_o, w_valid_o, busy_o, done_o}, 32'd0);
        resetn = 1'b1;
        @(negedge clock);

        // 1: 0x0D, len 4 -> 1,1,0,1 then done; LOAD visible right after the start edge.
        launch(8'h0D, 4'd4, 4'd0, 4'd0, n);
        chk("load_state", {29'b0, state_o}, 32'd1);
        chk("load_busy", {31'b0, busy_o}, 32'd1);
        expect_stream(n, 8'b0000_1101, 4, 0, 0);

        // 2: 0x0B, len 3, repeat 2, no gap -> 011 011 011 contiguous.
        launch(8'h0B, 4'd3, 4'd2, 4'd0, n);
        expect_stream(n, 8'b0000_0011, 3, 2, 0);

        // 3: 0x05, len 3, repeat 1, gap 2 -> 101, two idle cycles, 101.
        launch(8'h05, 4'd3, 4'd1, 4'd2, n);
        expect_stream(n, 8'b0000_0101, 3, 1, 2);

        // 4a: length 0 start is ignored.
        launch(8'hFF, 4'd0, 4'd0, 4'd0, n);
        chk("len0_busy", {31'b0, busy_o}, 32'd0);
        chk("len0_state", {29'b0, state_o}, 32'd0);
        // 4b: abort in IDLE blocks a simultaneous start.
        abort_i = 1'b1;
        launch(8'hFF, 4'd4, 4'd0, 4'd0, n);
        abort_i = 1'b0;
        chk("idle_abort_busy", {31'b0, busy_o}, 32'd0);
        chk("idle_abort_state", {29'b0, state_o}, 32'd0);
        @(negedge clock);
        // 4c: length 12 clamps to 8 bits of 0xA5.
        launch(8'hA5, 4'd12, 4'd0, 4'd0, n);
        expect_stream(n, 8'b1010_0101, 8, 0, 0);

        // 5: abort while the 2nd bit of 1001 is on the line.
        launch(8'h09, 4'd4, 4'd0, 4'd0, n);
        push(n + 1, 1'b0, 1'b1);
        push(n + 2, 1'b0, 1'b0);
        repeat (2) @(negedge clock);
        abort_i = 1'b1;
        @(negedge clock);
        abort_i = 1'b0;
        chk("abort_state", {29'b0, state_o}, 32'd0);
        chk("abort_outs", {28'b0, w_out_o, w_valid_o, busy_o, done_o}, 32'd0);
        launch(8'h0D, 4'd4, 4'd0, 4'd0, n);
        expect_stream(n, 8'b0000_1101, 4, 0, 0);

        // 6: start while busy ignored, then reset mid-GAP.
        launch(8'h05, 4'd3, 4'd1, 4'd3, n);
        push(n + 1, 1'b0, 1'b1);
        push(n + 2, 1'b0, 1'b0);
        push(n + 3, 1'b0, 1'b1);
        @(negedge clock);
        pattern_i = 8'hFF;
        length_i  = 4'd8;
        start_i   = 1'b1;
        @(negedge clock);
        start_i   = 1'b0;
        repeat (2) @(negedge clock);
        chk("gap_state", {29'b0, state_o}, 32'd3);
        chk("gap_valid", {31'b0, w_valid_o}, 32'd0);
        resetn = 1'b0;
        @(negedge clock);
        chk("midgap_rst_state", {29'b0, state_o}, 32'd0);
        chk("midgap_rst_outs", {28'b0, w_out_o, w_valid_o, busy_o, done_o}, 32'd0);
        resetn = 1'b1;
        repeat (4) @(negedge clock);

        // Recovery after reset: 0x0B, len 3, repeat 0.
        launch(8'h0B, 4'd3, 4'd0, 4'd0, n);
        expect_stream(n, 8'b0000_0011, 3, 0, 0);

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
